// File: rtl/ex_rs.sv
// Reservation station for one execution unit: holds dispatched entries until both
// operands are present (snooping the CDB), then issues them in index order.
module ex_rs #(
   parameter int DEPTH   = 4,
   parameter int UNIT_ID = 0,
   parameter int OP_W    = 6,
   parameter int TAG_W   = 4,
   parameter int VAL_W   = 32,
   parameter int UNIT_W  = 3
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [UNIT_W-1:0]            in_ex_unit,
   input  logic [OP_W-1:0]              in_op,
   input  logic [TAG_W-1:0]             in_tag1,
   input  logic [TAG_W-1:0]             in_tag2,
   input  logic [VAL_W-1:0]             in_val1,
   input  logic [VAL_W-1:0]             in_val2,
   input  logic [TAG_W-1:0]             in_target,
   input  logic                         cdb_valid,
   input  logic [TAG_W-1:0]             cdb_tag,
   input  logic [VAL_W-1:0]             cdb_val,
   output logic                         issue_valid,
   input  logic                         issue_ready,
   output logic [OP_W-1:0]              issue_op,
   output logic [VAL_W-1:0]             issue_val1,
   output logic [VAL_W-1:0]             issue_val2,
   output logic [TAG_W-1:0]             issue_target,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int IDX_W = $clog2(DEPTH);

   logic [DEPTH-1:0] busy_reg;
   logic [OP_W-1:0]  op_reg     [DEPTH];
   logic [TAG_W-1:0] tag1_reg   [DEPTH];
   logic [TAG_W-1:0] tag2_reg   [DEPTH];
   logic [VAL_W-1:0] val1_reg   [DEPTH];
   logic [VAL_W-1:0] val2_reg   [DEPTH];
   logic [TAG_W-1:0] target_reg [DEPTH];

   logic             issue_valid_reg;
   logic [OP_W-1:0]  issue_op_reg;
   logic [VAL_W-1:0] issue_val1_reg;
   logic [VAL_W-1:0] issue_val2_reg;
   logic [TAG_W-1:0] issue_target_reg;
   logic [CNT_W-1:0] count_reg;

   logic [DEPTH-1:0] ready_vec;
   logic [DEPTH-1:0] free_vec;
   logic [DEPTH-1:0] wake1_vec;
   logic [DEPTH-1:0] wake2_vec;
   logic [IDX_W-1:0] free_sel;
   logic [IDX_W-1:0] ready_sel;
   logic             cdb_live;
   logic             accept;
   logic             load;
   logic             bypass1;
   logic             bypass2;

   // A broadcast of tag 0 carries no producer and must never match anything.
   assign cdb_live = cdb_valid && (cdb_tag != '0);

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign ready_vec[gi] = busy_reg[gi] && (tag1_reg[gi] == '0) && (tag2_reg[gi] == '0);
      assign free_vec[gi]  = !busy_reg[gi];
      assign wake1_vec[gi] = busy_reg[gi] && cdb_live && (tag1_reg[gi] == cdb_tag);
      assign wake2_vec[gi] = busy_reg[gi] && cdb_live && (tag2_reg[gi] == cdb_tag);
   end

   // Descending scan so the lowest index wins.
   always_comb begin
      free_sel  = '0;
      ready_sel = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (free_vec[i])  free_sel  = IDX_W'(i);
         if (ready_vec[i]) ready_sel = IDX_W'(i);
      end
   end

   assign in_ready = (count_reg != CNT_W'(DEPTH));
   assign accept   = in_valid && in_ready && (in_ex_unit == UNIT_W'(UNIT_ID));
   assign load     = (!issue_valid_reg || issue_ready) && (|ready_vec);
   assign bypass1  = cdb_live && (in_tag1 == cdb_tag);
   assign bypass2  = cdb_live && (in_tag2 == cdb_tag);

   always_ff @(posedge clk) begin
      if (!rst || flush) begin
         busy_reg         <= '0;
         issue_valid_reg  <= 1'b0;
         issue_op_reg     <= '0;
         issue_val1_reg   <= '0;
         issue_val2_reg   <= '0;
         issue_target_reg <= '0;
         count_reg        <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (wake1_vec[i]) begin
               tag1_reg[i] <= '0;
               val1_reg[i] <= cdb_val;
            end
            if (wake2_vec[i]) begin
               tag2_reg[i] <= '0;
               val2_reg[i] <= cdb_val;
            end
         end

         if (load) begin
            busy_reg[ready_sel] <= 1'b0;
            issue_valid_reg     <= 1'b1;
            issue_op_reg        <= op_reg[ready_sel];
            issue_val1_reg      <= val1_reg[ready_sel];
            issue_val2_reg      <= val2_reg[ready_sel];
            issue_target_reg    <= target_reg[ready_sel];
         end else if (issue_ready) begin
            issue_valid_reg <= 1'b0;
         end

         // The free slot is never the one being issued, so these writes never collide.
         if (accept) begin
            busy_reg[free_sel]   <= 1'b1;
            op_reg[free_sel]     <= in_op;
            tag1_reg[free_sel]   <= bypass1 ? '0 : in_tag1;
            val1_reg[free_sel]   <= bypass1 ? cdb_val : in_val1;
            tag2_reg[free_sel]   <= bypass2 ? '0 : in_tag2;
            val2_reg[free_sel]   <= bypass2 ? cdb_val : in_val2;
            target_reg[free_sel] <= in_target;
         end

         case ({accept, load})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign issue_valid  = issue_valid_reg;
   assign issue_op     = issue_op_reg;
   assign issue_val1   = issue_val1_reg;
   assign issue_val2   = issue_val2_reg;
   assign issue_target = issue_target_reg;
   assign count        = count_reg;

endmodule

// File: tb/tb_ex_rs.sv
// Bench for ex_rs: directed scenarios with spec constants, then a randomized run
// checked cycle by cycle against an entry-list reference model.
module tb_ex_rs;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready;
   logic [2:0]  in_ex_unit;
   logic [5:0]  in_op;
   logic [3:0]  in_tag1, in_tag2, in_target;
   logic [31:0] in_val1, in_val2;
   logic        cdb_valid;
   logic [3:0]  cdb_tag;
   logic [31:0] cdb_val;
   logic        issue_valid, issue_ready;
   logic [5:0]  issue_op;
   logic [31:0] issue_val1, issue_val2;
   logic [3:0]  issue_target;
   logic [2:0]  count;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ex_rs dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_ex_unit(in_ex_unit),
      .in_op(in_op), .in_tag1(in_tag1), .in_tag2(in_tag2),
      .in_val1(in_val1), .in_val2(in_val2), .in_target(in_target),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
      .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
      .issue_val1(issue_val1), .issue_val2(issue_val2), .issue_target(issue_target),
      .count(count)
   );

   // Reference model: a list of four slots plus the issue register.
   typedef struct packed {
      bit        busy;
      bit [5:0]  op;
      bit [3:0]  t1, t2, tgt;
      bit [31:0] v1, v2;
   } ent_t;

   ent_t      m_ent [4];
   bit        m_iv;
   bit [5:0]  m_op;
   bit [31:0] m_v1, m_v2;
   bit [3:0]  m_tgt;
   int        m_cnt;

   task automatic model_step();
      ent_t nx [4];
      int   k, f;
      bit   ld, acc;
      if (!rst || flush) begin
         for (int e = 0; e < 4; e++) m_ent[e].busy = 0;
         m_iv = 0; m_op = 0; m_v1 = 0; m_v2 = 0; m_tgt = 0; m_cnt = 0;
         return;
      end
      k = -1; f = -1;
      for (int e = 3; e >= 0; e--) begin
         if (m_ent[e].busy && m_ent[e].t1 == 0 && m_ent[e].t2 == 0) k = e;
         if (!m_ent[e].busy) f = e;
      end
      ld  = (!m_iv || issue_ready) && (k >= 0);
      acc = in_valid && (in_ex_unit == 3'd0) && (m_cnt != 4) && (f >= 0);
      nx  = m_ent;
      for (int e = 0; e < 4; e++) begin
         if (nx[e].busy && cdb_valid && cdb_tag != 0) begin
            if (nx[e].t1 == cdb_tag) begin nx[e].t1 = 0; nx[e].v1 = cdb_val; end
            if (nx[e].t2 == cdb_tag) begin nx[e].t2 = 0; nx[e].v2 = cdb_val; end
         end
      end
      if (ld) begin
         m_op = m_ent[k].op; m_v1 = m_ent[k].v1; m_v2 = m_ent[k].v2; m_tgt = m_ent[k].tgt;
         nx[k].busy = 0;
         m_iv = 1;
      end else if (issue_ready) begin
         m_iv = 0;
      end
      if (acc) begin
         nx[f].busy = 1; nx[f].op = in_op; nx[f].tgt = in_target;
         nx[f].t1 = in_tag1; nx[f].v1 = in_val1;
         nx[f].t2 = in_tag2; nx[f].v2 = in_val2;
         if (cdb_valid && cdb_tag != 0 && in_tag1 == cdb_tag) begin nx[f].t1 = 0; nx[f].v1 = cdb_val; end
         if (cdb_valid && cdb_tag != 0 && in_tag2 == cdb_tag) begin nx[f].t2 = 0; nx[f].v2 = cdb_val; end
      end
      m_ent = nx;
      m_cnt = 0;
      for (int e = 0; e < 4; e++) m_cnt += int'(m_ent[e].busy);
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      flush = 0; in_valid = 0; in_ex_unit = 0; in_op = 0;
      in_tag1 = 0; in_tag2 = 0; in_val1 = 0; in_val2 = 0; in_target = 0;
      cdb_valid = 0; cdb_tag = 0; cdb_val = 0; issue_ready = 1;
   endtask

   task automatic dispatch(input bit [5:0] op, input bit [3:0] t1, input bit [3:0] t2,
                           input bit [31:0] v1, input bit [31:0] v2, input bit [3:0] tgt);
      in_valid = 1; in_ex_unit = 0; in_op = op;
      in_tag1 = t1; in_tag2 = t2; in_val1 = v1; in_val2 = v2; in_target = tgt;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 0;
      tick(); tick();
      n_vec++; if (issue_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b want 0", issue_valid); end
      n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
      n_vec++; if ({issue_op, issue_val1, issue_val2, issue_target} !== '0) begin n_err++;
         $display("FAIL reset_issue_fields: got op=%0d v1=%h v2=%h tgt=%0d want 0", issue_op, issue_val1, issue_val2, issue_target); end
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
      rst = 1;
      tick();
   endtask

   task automatic test_basic();
      dispatch(6'd5, 4'd0, 4'd0, 32'd10, 32'd20, 4'd3);
      tick();
      in_valid = 0;
      n_vec++; if (issue_valid !== 1'b0 || count !== 3'd1) begin n_err++;
         $display("FAIL basic_c1: got valid=%0b count=%0d want valid=0 count=1", issue_valid, count); end
      tick();
      n_vec++; if (issue_valid !== 1'b1 || issue_op !== 6'd5 || issue_val1 !== 32'd10 || issue_val2 !== 32'd20 || issue_target !== 4'd3) begin n_err++;
         $display("FAIL basic_issue: got v=%0b op=%0d %0d/%0d tgt=%0d want 1 5 10/20 3", issue_valid, issue_op, issue_val1, issue_val2, issue_target); end
      n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL basic_count: got %0d want 0", count); end
      tick();
      n_vec++; if (issue_valid !== 1'b0) begin n_err++; $display("FAIL basic_drain: got %0b want 0", issue_valid); end
   endtask

   task automatic test_wakeup();
      dispatch(6'd1, 4'd7, 4'd0, 32'd0, 32'h22, 4'd4);
      tick();
      in_valid = 0;
      tick();
      cdb_valid = 1; cdb_tag = 4'd7; cdb_val = 32'hAB;
      tick();
      cdb_valid = 0;
      n_vec++; if (issue_valid !== 1'b0) begin n_err++; $display("FAIL wake_early: got %0b want 0", issue_valid); end
      tick();
      n_vec++; if (issue_valid !== 1'b1 || issue_val1 !== 32'hAB || issue_val2 !== 32'h22 || issue_target !== 4'd4) begin n_err++;
         $display("FAIL wake_issue: got v=%0b %h/%h tgt=%0d want 1 ab/22 4", issue_valid, issue_val1, issue_val2, issue_target); end
   endtask

   task automatic test_bypass();
      dispatch(6'd2, 4'd9, 4'd9, 32'd0, 32'd0, 4'd6);
      cdb_valid = 1; cdb_tag = 4'd9; cdb_val = 32'h55;
      tick();
      in_valid = 0; cdb_valid = 0;
      n_vec++; if (issue_valid !== 1'b0 || count !== 3'd1) begin n_err++;
         $display("FAIL bypass_c1: got valid=%0b count=%0d want 0/1", issue_valid, count); end
      tick();
      n_vec++; if (issue_valid !== 1'b1 || issue_val1 !== 32'h55 || issue_val2 !== 32'h55) begin n_err++;
         $display("FAIL bypass_issue: got v=%0b %h/%h want 1 55/55", issue_valid, issue_val1, issue_val2); end
      tick();
   endtask

   task automatic test_fill();
      for (int i = 0; i < 4; i++) begin
         dispatch(6'(10 + i), 4'd2, 4'd0, 32'd0, 32'(i), 4'(i + 1));
         tick();
      end
      n_vec++; if (count !== 3'd4 || in_ready !== 1'b0) begin n_err++;
         $display("FAIL fill_full: got count=%0d in_ready=%0b want 4/0", count, in_ready); end
      dispatch(6'd14, 4'd0, 4'd0, 32'd1, 32'd1, 4'd9);
      tick();
      in_valid = 0;
      n_vec++; if (count !== 3'd4 || issue_valid !== 1'b0) begin n_err++;
         $display("FAIL fill_extra: got count=%0d valid=%0b want 4/0", count, issue_valid); end
      cdb_valid = 1; cdb_tag = 4'd2; cdb_val = 32'h77;
      tick();
      cdb_valid = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_vec++; if (issue_valid !== 1'b1 || issue_op !== 6'(10 + i) || issue_val1 !== 32'h77 || count !== 3'(3 - i)) begin n_err++;
            $display("FAIL fill_order%0d: got v=%0b op=%0d v1=%h count=%0d want 1 %0d 77 %0d", i, issue_valid, issue_op, issue_val1, count, 10 + i, 3 - i); end
      end
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready_again: got %0b want 1", in_ready); end
      tick();
   endtask

   task automatic test_hold();
      issue_ready = 0;
      dispatch(6'd20, 4'd0, 4'd0, 32'd1, 32'd2, 4'd1);
      tick();
      dispatch(6'd21, 4'd0, 4'd0, 32'd3, 32'd4, 4'd2);
      tick();
      in_valid = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_vec++; if (issue_valid !== 1'b1 || issue_op !== 6'd20 || issue_val1 !== 32'd1 || count !== 3'd1) begin n_err++;
            $display("FAIL hold_stable%0d: got v=%0b op=%0d v1=%0d count=%0d want 1 20 1 1", i, issue_valid, issue_op, issue_val1, count); end
      end
      issue_ready = 1;
      tick();
      n_vec++; if (issue_valid !== 1'b1 || issue_op !== 6'd21 || issue_target !== 4'd2 || count !== 3'd0) begin n_err++;
         $display("FAIL hold_release: got v=%0b op=%0d tgt=%0d count=%0d want 1 21 2 0", issue_valid, issue_op, issue_target, count); end
      tick();
   endtask

   task automatic test_flush();
      issue_ready = 0;
      dispatch(6'd30, 4'd0, 4'd0, 32'd1, 32'd1, 4'd1);
      tick();
      for (int i = 0; i < 3; i++) begin
         dispatch(6'(31 + i), 4'd5, 4'd0, 32'd0, 32'd0, 4'(2 + i));
         tick();
      end
      in_valid = 0;
      n_vec++; if (count !== 3'd3 || issue_valid !== 1'b1) begin n_err++;
         $display("FAIL flush_pre: got count=%0d valid=%0b want 3/1", count, issue_valid); end
      flush = 1;
      dispatch(6'd40, 4'd0, 4'd0, 32'd9, 32'd9, 4'd9);
      cdb_valid = 1; cdb_tag = 4'd5; cdb_val = 32'h1;
      tick();
      flush = 0; in_valid = 0; cdb_valid = 0; issue_ready = 1;
      n_vec++; if (count !== 3'd0 || issue_valid !== 1'b0 || in_ready !== 1'b1 || issue_op !== 6'd0) begin n_err++;
         $display("FAIL flush_clear: got count=%0d valid=%0b in_ready=%0b op=%0d want 0 0 1 0", count, issue_valid, in_ready, issue_op); end
      dispatch(6'd41, 4'd0, 4'd0, 32'd1, 32'd1, 4'd1);
      in_ex_unit = 3'd3;
      tick();
      in_valid = 0; in_ex_unit = 0;
      n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL wrong_unit_count: got %0d want 0", count); end
      tick();
      n_vec++; if (issue_valid !== 1'b0) begin n_err++; $display("FAIL wrong_unit_issue: got %0b want 0", issue_valid); end
   endtask

   task automatic test_random();
      for (int cyc = 0; cyc < 600; cyc++) begin
         rst         = ($urandom_range(99) != 0);
         flush       = ($urandom_range(49) == 0);
         in_valid    = ($urandom_range(1) == 1);
         in_ex_unit  = ($urandom_range(7) == 0) ? 3'(1 + $urandom_range(6)) : 3'd0;
         in_op       = 6'($urandom);
         in_tag1     = ($urandom_range(1) == 1) ? 4'd0 : 4'($urandom_range(6));
         in_tag2     = ($urandom_range(1) == 1) ? 4'd0 : 4'($urandom_range(6));
         in_val1     = $urandom;
         in_val2     = $urandom;
         in_target   = 4'($urandom);
         cdb_valid   = ($urandom_range(2) != 0);
         cdb_tag     = 4'($urandom_range(6));
         cdb_val     = $urandom;
         issue_ready = ($urandom_range(9) < 7);
         tick();
         n_vec++; if (count !== 3'(m_cnt) || in_ready !== (m_cnt != 4)) begin n_err++;
            $display("FAIL rand_count cyc%0d: got count=%0d in_ready=%0b want %0d %0b", cyc, count, in_ready, m_cnt, m_cnt != 4); end
         n_vec++; if (issue_valid !== m_iv) begin n_err++;
            $display("FAIL rand_valid cyc%0d: got %0b want %0b", cyc, issue_valid, m_iv); end
         if (m_iv) begin
            n_vec++; if (issue_op !== m_op || issue_val1 !== m_v1 || issue_val2 !== m_v2 || issue_target !== m_tgt) begin n_err++;
               $display("FAIL rand_issue cyc%0d: got op=%0d %h/%h tgt=%0d want op=%0d %h/%h tgt=%0d",
                        cyc, issue_op, issue_val1, issue_val2, issue_target, m_op, m_v1, m_v2, m_tgt); end
         end
      end
   endtask

   initial begin
      rst = 0;
      idle_inputs();
      test_reset();
      test_basic();
      test_wakeup();
      test_bypass();
      test_fill();
      test_hold();
      test_flush();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
